// File: rtl/cnt_min_hr.sv
// cnt_min_hr: BCD minutes/hours time-of-day counter with button time-set FSM and blink.
// Define CNT_MIN_HR_12H_EN for 12-hour mode (12,01..11) with an added pm output.
module cnt_min_hr #(
  parameter int SYNC_STAGES = 2,
  parameter int BLINK_PERIOD = 50
) (
  input  logic       in_clk,
  input  logic       rst,
  input  logic       sec_tick,
  input  logic       btn_mode,
  input  logic       btn_inc,
  output logic [3:0] min_ones,
  output logic [3:0] min_tens,
  output logic [3:0] hr_ones,
  output logic [3:0] hr_tens,
  output logic [1:0] set_mode,
  output logic       blink,
`ifdef CNT_MIN_HR_12H_EN
  output logic       pm,
`endif
  output logic       day_pulse
);
  typedef enum logic [1:0] {RUN = 2'b00, SET_HR = 2'b01, SET_MIN = 2'b10} state_t;
  localparam int BW = $clog2(BLINK_PERIOD + 1);
  state_t state, state_n;
  logic [SYNC_STAGES-1:0] mode_sync, inc_sync, fill;
  logic mode_s, inc_s, mode_prev, inc_prev, mode_arm, inc_arm, mode_ev, inc_ev;
  logic [BW-1:0] bcnt, bcnt_n;
  logic blink_n, day_n, run_blink, min_wrap, hr_wrap, day_hit;
  logic [3:0] mo_n, mt_n, ho_n, ht_n, mo_inc, mt_inc, ho_inc, ht_inc;
`ifdef CNT_MIN_HR_12H_EN
  logic pm_n, hr_top;
`endif
  assign mode_s = mode_sync[SYNC_STAGES-1];
  assign inc_s = inc_sync[SYNC_STAGES-1];
  // arm only after the chain has seen the button released, so a press held through reset is ignored
  assign mode_ev = mode_s & ~mode_prev & mode_arm;
  assign inc_ev = inc_s & ~inc_prev & inc_arm;
  assign set_mode = state;
  always_comb begin
    min_wrap = min_tens >= 4'd5 && min_ones >= 4'd9;
    mo_inc = min_ones >= 4'd9 ? 4'd0 : min_ones + 4'd1;
    mt_inc = min_ones < 4'd9 ? min_tens : min_tens >= 4'd5 ? 4'd0 : min_tens + 4'd1;
`ifdef CNT_MIN_HR_12H_EN
    hr_wrap = hr_tens == 4'd1 && hr_ones == 4'd1;
    hr_top = hr_tens >= 4'd1 && hr_ones >= 4'd2;
    ho_inc = hr_top ? 4'd1 : hr_ones >= 4'd9 ? 4'd0 : hr_ones + 4'd1;
    ht_inc = hr_top ? 4'd0 : hr_ones >= 4'd9 ? 4'd1 : hr_tens;
    day_hit = min_wrap & hr_wrap & pm;
`else
    hr_wrap = hr_tens >= 4'd2 && hr_ones >= 4'd3;
    ho_inc = hr_wrap || hr_ones >= 4'd9 ? 4'd0 : hr_ones + 4'd1;
    ht_inc = hr_wrap ? 4'd0 : hr_ones >= 4'd9 ? hr_tens + 4'd1 : hr_tens;
    day_hit = min_wrap & hr_wrap;
`endif
  end
  always_comb begin
    state_n = state;
    {mt_n, mo_n, ht_n, ho_n} = {min_tens, min_ones, hr_tens, hr_ones};
    day_n = 1'b0;
`ifdef CNT_MIN_HR_12H_EN
    pm_n = pm;
`endif
    case (state)
      RUN: begin
        state_n = mode_ev ? SET_HR : RUN;
        if (sec_tick) begin
          {mt_n, mo_n} = {mt_inc, mo_inc};
          {ht_n, ho_n} = min_wrap ? {ht_inc, ho_inc} : {hr_tens, hr_ones};
          day_n = day_hit;
`ifdef CNT_MIN_HR_12H_EN
          pm_n = pm ^ (min_wrap & hr_wrap);
`endif
        end
      end
      SET_HR: begin
        state_n = mode_ev ? SET_MIN : SET_HR;
        if (inc_ev && !mode_ev) begin
          {ht_n, ho_n} = {ht_inc, ho_inc};
`ifdef CNT_MIN_HR_12H_EN
          pm_n = pm ^ hr_wrap;
`endif
        end
      end
      SET_MIN: begin
        state_n = mode_ev ? RUN : SET_MIN;
        if (inc_ev && !mode_ev) {mt_n, mo_n} = {mt_inc, mo_inc};
      end
      default: state_n = RUN;
    endcase
    run_blink = state_n == state && state != RUN;
    bcnt_n = !run_blink || bcnt == BW'(BLINK_PERIOD - 1) ? '0 : bcnt + 1'b1;
    blink_n = run_blink && (bcnt == BW'(BLINK_PERIOD - 1) ? ~blink : blink);
  end
  always_ff @(posedge in_clk or negedge rst)
    if (!rst) begin
      mode_sync <= '0;
      inc_sync <= '0;
      fill <= '0;
      mode_prev <= 1'b0;
      inc_prev <= 1'b0;
      mode_arm <= 1'b0;
      inc_arm <= 1'b0;
      state <= RUN;
      bcnt <= '0;
      blink <= 1'b0;
      day_pulse <= 1'b0;
      min_ones <= 4'd0;
      min_tens <= 4'd0;
`ifdef CNT_MIN_HR_12H_EN
      hr_tens <= 4'd1;
      hr_ones <= 4'd2;
      pm <= 1'b0;
`else
      hr_tens <= 4'd0;
      hr_ones <= 4'd0;
`endif
    end else begin
      mode_sync <= {mode_sync[SYNC_STAGES-2:0], btn_mode};
      inc_sync <= {inc_sync[SYNC_STAGES-2:0], btn_inc};
      fill <= {fill[SYNC_STAGES-2:0], 1'b1};
      mode_prev <= mode_s;
      inc_prev <= inc_s;
      mode_arm <= mode_arm | (fill[SYNC_STAGES-1] & ~mode_s);
      inc_arm <= inc_arm | (fill[SYNC_STAGES-1] & ~inc_s);
      state <= state_n;
      bcnt <= bcnt_n;
      blink <= blink_n;
      day_pulse <= day_n;
      {min_tens, min_ones, hr_tens, hr_ones} <= {mt_n, mo_n, ht_n, ho_n};
`ifdef CNT_MIN_HR_12H_EN
      pm <= pm_n;
`endif
    end
endmodule
